// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: word sizes, multiplier FSM states and
// the iteration-counter width helper.
package dsp_pkg;

  localparam int DSP_WORD  = 16;
  localparam int DSP_DWORD = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mpy_state_t;

  // Width of a counter that walks 0..w-1; never collapses below one bit.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  localparam int MPY_CNT_W = cnt_width(DSP_WORD);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the upper accumulator, then arithmetic shift right of the whole register.
module booth_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH+1:0] acc_in,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH+1:0] acc_out
);

  logic [WIDTH:0]     mc_ext;
  logic [WIDTH:0]     upper;
  logic [2*WIDTH+1:0] sum;

  // Register layout: {upper[WIDTH:0], multiplier[WIDTH-1:0], q_minus1}
  always_comb begin
    mc_ext = {mcand[WIDTH-1], mcand};
    upper  = acc_in[2*WIDTH+1:WIDTH+1];
    case (acc_in[1:0])
      2'b01:   upper = upper + mc_ext;
      2'b10:   upper = upper - mc_ext;
      default: upper = acc_in[2*WIDTH+1:WIDTH+1];
    endcase
    sum     = {upper, acc_in[WIDTH:0]};
    acc_out = {sum[2*WIDTH+1], sum[2*WIDTH+1:1]};
  end

endmodule

// File: rtl/mpy_unit.sv
// Sequential signed T x operand multiplier feeding the P register.
// state | meaning
// IDLE  | waiting for start
// RUN   | one Booth iteration per cycle, WIDTH cycles
// DONE  | P holds the new product for one cycle; start here chains a new multiply
module mpy_unit
  import dsp_pkg::*;
#(
  parameter int WIDTH = DSP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_t,
  input  logic [WIDTH-1:0]   t_in,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  input  logic               clear_p,
  output logic [WIDTH-1:0]   t_out,
  output logic [2*WIDTH-1:0] p_out,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_width(WIDTH);
  localparam int BW = 2*WIDTH + 2;

  mpy_state_t         state, state_nx;
  logic [WIDTH-1:0]   t_reg;
  logic [WIDTH-1:0]   mcand;
  logic [BW-1:0]      booth;
  logic [BW-1:0]      booth_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p_reg;
  logic               last;
  logic               accept;

  assign last   = (cnt == CW'(WIDTH-1));
  assign accept = start && (state != RUN);

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (booth),
    .mcand   (mcand),
    .acc_out (booth_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_reg <= '0;
      mcand <= '0;
      booth <= '0;
      cnt   <= '0;
      p_reg <= '0;
    end else begin
      if (load_t) t_reg <= t_in;
      // mcand captures T before any same-edge load_t lands
      if (accept) begin
        mcand <= t_reg;
        booth <= {{(WIDTH+1){1'b0}}, operand, 1'b0};
        cnt   <= '0;
      end else if (state == RUN) begin
        booth <= booth_nx;
        cnt   <= cnt + CW'(1);
      end
      if (state == RUN && last) p_reg <= booth_nx[2*WIDTH:1];
      else if (clear_p)         p_reg <= '0;
    end
  end

  assign t_out = t_reg;
  assign p_out = p_reg;
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_mpy_unit.sv
// Scoreboard bench for mpy_unit: the driver pushes expected products (computed
// by plain signed arithmetic) and a monitor checks them whenever done pulses.
module tb_mpy_unit;

  logic        clk = 0;
  logic        reset = 1;
  logic        load_t = 0;
  logic [15:0] t_in = '0;
  logic        start = 0;
  logic [15:0] operand = '0;
  logic        clear_p = 0;
  logic [15:0] t_out;
  logic [31:0] p_out;
  logic        busy;
  logic        done;

  mpy_unit #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .load_t  (load_t),
    .t_in    (t_in),
    .start   (start),
    .operand (operand),
    .clear_p (clear_p),
    .t_out   (t_out),
    .p_out   (p_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model_t = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp = n_cmp + 1;
    if (act !== expv) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("product", p_out, mon_e.prod);
        check("done_cycle", cyc, mon_e.due);
      end
    end
  end

  // Advance to the next negedge and drop one-cycle pulses.
  task automatic apply();
    @(negedge clk);
    start   = 0;
    load_t  = 0;
    clear_p = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    load_t  = 1;
    t_in    = v;
    model_t = v;
    apply();
  endtask

  // Drive start at the current negedge; expected product uses T before any same-edge load.
  task automatic issue(input logic [15:0] op, input bit ld, input logic [15:0] nt);
    exp_t e;
    e.prod  = ref_prod(model_t, op);
    e.due   = cyc + 17;
    sb.push_back(e);
    start   = 1;
    operand = op;
    if (ld) begin
      load_t  = 1;
      t_in    = nt;
      model_t = nt;
    end
    apply();
  endtask

  task automatic mul_seq(input logic [15:0] a, input logic [15:0] b);
    load(a);
    issue(b, 0, '0);
    wait_cycles(16);
    apply();
    check("busy_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a, b;
    bit          chained;
    int          r;

    wait_cycles(3);
    check("rst_t", {16'b0, t_out}, 32'd0);
    check("rst_p", p_out, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    reset = 0;
    apply();

    load(16'h0001);
    check("t_load", {16'b0, t_out}, 32'h0001);
    issue(16'h0001, 0, '0);
    check("busy_run", {31'b0, busy}, 32'd1);
    wait_cycles(16);
    check("t_kept", {16'b0, t_out}, 32'h0001);
    apply();
    check("busy_idle", {31'b0, busy}, 32'd0);

    mul_seq(16'h0003, 16'h0005);
    mul_seq(16'hFFFF, 16'h0001);
    mul_seq(16'h8000, 16'h8000);
    mul_seq(16'h7FFF, 16'h8000);

    // start during RUN is ignored, then chain a multiply from DONE
    load(16'h0003);
    issue(16'h0005, 0, '0);
    wait_cycles(4);
    start = 1; operand = 16'h0007;
    apply();
    wait_cycles(11);
    issue(16'h0002, 0, '0);
    check("chain_busy", {31'b0, busy}, 32'd1);
    wait_cycles(16);
    apply();

    // load_t mid-run must not disturb the latched multiplicand
    load(16'h0004);
    issue(16'h0004, 0, '0);
    wait_cycles(2);
    load(16'h0009);
    wait_cycles(13);
    check("t_midrun", {16'b0, t_out}, 32'h0009);
    apply();
    issue(16'h0003, 1, 16'h0005);
    check("t_same_edge", {16'b0, t_out}, 32'h0005);
    wait_cycles(16);
    apply();

    // reset mid-run discards the result
    issue(16'h0007, 0, '0);
    wait_cycles(7);
    reset = 1;
    sb.delete();
    apply();
    model_t = '0;
    check("midrst_t", {16'b0, t_out}, 32'd0);
    check("midrst_p", p_out, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    reset = 0;
    wait_cycles(20);
    mul_seq(16'h0002, 16'h0003);

    clear_p = 1;
    apply();
    check("clear_idle", p_out, 32'd0);

    // clear_p on the final RUN edge loses to the product
    load(16'h0003);
    issue(16'h0005, 0, '0);
    wait_cycles(15);
    clear_p = 1;
    apply();
    apply();

    chained = 0;
    for (int it = 0; it < 30; it++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (!chained) load(a);
      issue(b, ($urandom_range(0, 3) == 0), 16'($urandom));
      for (int c = 0; c < 16; c++) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          start = 1; operand = 16'($urandom);
        end else if (r == 1) begin
          load_t = 1; t_in = 16'($urandom); model_t = t_in;
        end else if (r == 2) begin
          clear_p = 1;
        end
        apply();
        if (r == 1) check("rand_t", {16'b0, t_out}, {16'b0, model_t});
        if (r == 2 && c < 15) check("rand_clear", p_out, 32'd0);
      end
      chained = ($urandom_range(0, 1) == 1);
      if (!chained) apply();
    end
    if (chained) apply();

    for (int w = 0; w < 40 && sb.size() != 0; w++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
